// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver.
// Contents:
//   upd_entry_t        - one predictor update {pc, ctr, target, alloc}
//   SNT/WNT/WT/ST      - 2-bit saturating counter states
//   UPD_DEPTH_DEFAULT  - default depth of the predictor-update queue
//   next_ctr()         - trained counter value for a resolved instruction
package branch_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam int UPD_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  ctr;
    logic [31:0] target;
    logic        alloc;
  } upd_entry_t;

  // Jumps always train to strongly-taken; branches saturate at SNT/ST.
  function automatic logic [1:0] next_ctr(input logic is_jump,
                                          input logic taken,
                                          input logic [1:0] ctr);
    logic [1:0] res;
    if (is_jump)          res = ST;
    else if (taken)       res = (ctr == ST)  ? ST  : ctr + 2'd1;
    else                  res = (ctr == SNT) ? SNT : ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_resolver_upd_fifo.sv
// upd_fifo: circular queue of predictor-update entries.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (empties the queue)
//   push        - write push_data this cycle (accepted when not full, or
//                 when full and a pop happens in the same cycle)
//   push_data   - entry to enqueue
//   valid       - queue not empty; head shows the oldest entry
//   ready       - consumer takes the head when valid & ready
//   count       - current occupancy
module upd_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = UPD_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  upd_entry_t               push_data,
  output logic                     valid,
  input  logic                     ready,
  output upd_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  upd_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            pop;
  logic            wr_en;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid & ready;
  // A pop frees the slot the push needs, so a full queue still takes a push.
  assign wr_en = push & (~full | pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves control-transfer instructions in EX, redirects
// fetch on a mispredict and queues predictor (BHT/BTB) training updates.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   ex_valid, ex_is_jump         - instruction present / unconditional jump
//   ex_pc, ex_taken, ex_target   - PC, actual outcome, actual taken target
//   ex_pred_taken/target/ctr     - fetch-time prediction and its counter
//   PCSrc, t_addr                - fetch redirect strobe and address
//   flush                        - squash wrong-path IF/ID contents
//   stall_req                    - EX must hold (update queue has no room)
//   upd_valid/ready, upd_pc/ctr/target/alloc - predictor update stream
//   stat_branches, stat_mispredicts          - resolved / mispredict counts
module branch_resolver
  import branch_pkg::*;
#(
  parameter int UPD_DEPTH = UPD_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic [1:0]  ex_pred_ctr,
  output logic        PCSrc,
  output logic [31:0] t_addr,
  output logic        flush,
  output logic        stall_req,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [1:0]  upd_ctr,
  output logic [31:0] upd_target,
  output logic        upd_alloc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int CW = $clog2(UPD_DEPTH) + 1;

  logic          actual_taken;
  logic          tgt_mis;
  logic          mispred;
  logic          accept;
  logic          pop;
  upd_entry_t    entry_p0;
  upd_entry_t    entry_p1;
  logic          vld_p1;
  logic          redirect_p1;
  logic [31:0]   taddr_p1;
  upd_entry_t    head;
  logic [CW-1:0] fifo_count;

  always_comb begin
    actual_taken    = ex_is_jump | ex_taken;
    tgt_mis         = (ex_target != ex_pred_target);
    mispred         = (actual_taken != ex_pred_taken) |
                      (actual_taken & ex_pred_taken & tgt_mis);
    entry_p0.pc     = ex_pc;
    entry_p0.ctr    = next_ctr(ex_is_jump, ex_taken, ex_pred_ctr);
    entry_p0.target = ex_target;
    entry_p0.alloc  = actual_taken & (~ex_pred_taken | tgt_mis);
  end

  // Counting the not-yet-pushed entry keeps the queue from ever being asked
  // to take a push it has no room for; a pop this cycle frees a slot.
  assign pop       = upd_valid & upd_ready;
  assign stall_req = ((int'(fifo_count) + int'(vld_p1)) >= UPD_DEPTH) && !pop;
  // The instruction in EX during a flush cycle is wrong-path and is dropped.
  assign accept    = ex_valid & ~stall_req & ~redirect_p1;

  // ---- p0 -> p1: resolution registered, redirect and stats visible ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1           <= 1'b0;
      redirect_p1      <= 1'b0;
      taddr_p1         <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      vld_p1      <= accept;
      redirect_p1 <= accept & mispred;
      if (accept & mispred)
        taddr_p1 <= actual_taken ? ex_target : ex_pc + 32'd4;
      if (accept)
        stat_branches <= stat_branches + 32'd1;
      if (accept & mispred)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) entry_p1 <= entry_p0;
  end

  assign PCSrc  = redirect_p1;
  assign flush  = redirect_p1;
  assign t_addr = taddr_p1;

  // ---- p1 -> queue: update entry enqueued the cycle after accept ----
  upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (entry_p1),
    .valid     (upd_valid),
    .ready     (upd_ready),
    .head      (head),
    .count     (fifo_count)
  );

  assign upd_pc     = head.pc;
  assign upd_ctr    = head.ctr;
  assign upd_target = head.target;
  assign upd_alloc  = head.alloc;

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 4, meaning depth of the predictor-update FIFO (power of two, min 2).
REQ-002 SHALL have ports `clk` in 1 (the single clock) and `rst` in 1 (synchronous, active-high reset).
REQ-003 SHALL have `ex_valid` in 1: a control-transfer instruction is presented in EX this cycle.
REQ-004 SHALL have `ex_is_jump` in 1: the instruction is an unconditional jump (else a conditional branch).
REQ-005 SHALL have `ex_pc` in 32 (instruction PC) and `ex_taken` in 1 (actual outcome).
REQ-006 SHALL have `ex_target` in 32: the actual taken target.
REQ-007 SHALL have `ex_pred_taken` in 1, `ex_pred_target` in 32 and `ex_pred_ctr` in 2: the fetch-time prediction and the 2-bit counter value carried down the pipe.
REQ-008 SHALL have `PCSrc` out 1 (redirect fetch) and `t_addr` out 32 (redirect address), both to the fetch stage.
REQ-009 SHALL have `flush` out 1: squash the wrong-path IF/ID contents.
REQ-010 SHALL have `stall_req` out 1: EX must hold its instruction.
REQ-011 SHALL have `upd_valid` out 1 and `upd_ready` in 1: the update handshake to the BHT/BTB write port.
REQ-012 SHALL have `upd_pc` out 32, `upd_ctr` out 2, `upd_target` out 32 and `upd_alloc` out 1 (write or replace the BTB entry).
REQ-013 SHALL have `stat_branches` out 32 and `stat_mispredicts` out 32: resolved and mispredicted counts.

Function
REQ-014 SHALL accept an instruction in cycle N only when ex_valid=1, stall_req=0 and flush=0; in all other cases ex_valid is ignored.
REQ-015 SHALL treat a jump as actual taken=1 regardless of ex_taken.
REQ-016 SHALL declare a mispredict when actual taken != ex_pred_taken, or when both are taken and ex_target != ex_pred_target.
REQ-017 SHALL, on an accepted mispredict in cycle N, drive PCSrc=1 and flush=1 for exactly cycle N+1 (registered, 1-cycle latency).
REQ-018 SHALL, in that same cycle, drive t_addr = ex_target if actual taken, else ex_pc+4; the +4 wraps modulo 2^32.
REQ-019 SHALL hold PCSrc=0 and flush=0 otherwise, and hold t_addr at its last value.
REQ-020 SHALL compute the next counter value for a branch as: taken -> min(3, ex_pred_ctr+1); not taken -> max(0, ex_pred_ctr-1). For a jump it SHALL be 3.
REQ-021 SHALL set upd_alloc = actual taken AND (ex_pred_taken=0 OR target mismatch), and upd_target = ex_target.
REQ-022 SHALL push one update entry {pc, ctr, target, alloc} into the FIFO in cycle N+1 for every accepted instruction.
REQ-023 SHALL drive upd_valid = FIFO not empty, with the outputs showing the head entry.
REQ-024 SHALL pop the head on upd_valid AND upd_ready.
REQ-025 SHALL keep the head entry stable while upd_valid=1 and upd_ready=0.
REQ-026 SHALL drive stall_req=1 combinationally when the FIFO occupancy plus a pending push is >= UPD_DEPTH and no pop occurs this cycle.
REQ-027 SHALL perform a simultaneous push and pop on a full FIFO without loss and without asserting stall_req.
REQ-028 SHALL increment stat_branches per accepted instruction and stat_mispredicts per accepted mispredict, in cycle N+1, wrapping at 2^32.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, set PCSrc=0, flush=0, t_addr=0, upd_valid=0, stall_req=0, FIFO empty and both stat counters 0.
REQ-030 SHALL discard pending redirects and queued updates when rst is asserted mid-operation; the first accept is possible in the cycle after rst deasserts.

Structure
REQ-031 SHALL take from the shared package branch_pkg: the update-entry struct, the counter constants (SNT=0, WNT=1, WT=2, ST=3) and UPD_DEPTH default.
REQ-032 SHALL implement the queue as one sub-module, upd_fifo (parameterised depth, valid/ready pop, push/pop-same-cycle safe).

Verification
REQ-033 SHALL check a correct prediction: branch pc=0x100, taken=1, pred_taken=1, target 0x200 = pred 0x200, ctr=2 -> PCSrc stays 0; update {0x100, 3, 0x200, alloc=0}; stat_branches=1.
REQ-034 SHALL check a direction mispredict: pc=0x40, taken=0, pred_taken=1, ctr=2 -> next cycle PCSrc=flush=1, t_addr=0x44, upd_ctr=1; stat_mispredicts=1.
REQ-035 SHALL check a target mispredict on a jump: pc=0x80, target 0x300, pred_target 0x280, pred_taken=1, ctr=0 -> t_addr=0x300, upd_ctr=3, upd_alloc=1.
REQ-036 SHALL check wrap: pc=0xFFFFFFFC, taken=0, pred_taken=1 -> t_addr=0x00000000.
REQ-037 SHALL check backpressure: upd_ready=0, 5 back-to-back accepts with depth 4 -> stall_req=1 on the 5th, the 5th is not counted, and the order is preserved when upd_ready=1.
REQ-038 SHALL check shadow and reset: ex_valid=1 in the flush cycle -> ignored; rst mid-queue -> upd_valid=0 and counters 0 in the next cycle.
